// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: op codes, FSM states, default widths.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] GT  = 3'd2;
  localparam logic [2:0] EQ  = 3'd3;
  localparam logic [2:0] LT  = 3'd4;
  localparam logic [2:0] AND = 3'd5;
  localparam logic [2:0] OR  = 3'd6;
  localparam logic [2:0] XOR = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Registers commands onto an external ALU, holds them for SETTLE_CYCLES, returns the captured result.
// Optional macro ALU_CHAIN_EN: cmd_chain selects the previous result as operand A.
module alu_cmd_sequencer #(
  parameter int DATA_W        = alu_pkg::DATA_W,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = alu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_chain,
  output logic [2:0]        alu_op_code,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W:0]   alu_result,
  input  logic              alu_zero,
  input  logic              alu_control,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W:0]   rsp_result,
  output logic              rsp_zero,
  output logic              rsp_control,
  output logic [CNT_W-1:0]  op_count,
  output logic              busy
);
  import alu_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid && ready; a
  // producer holds valid and its payload stable until that edge.

  state_e              state_q, state_d;
  logic [3:0]          settle_cnt_q, settle_cnt_d;
  logic [2:0]          alu_op_code_q, alu_op_code_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [DATA_W:0]     rsp_result_q, rsp_result_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic                rsp_control_q, rsp_control_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]    op_count_q, op_count_d;

`ifdef ALU_CHAIN_EN
  logic [DATA_W-1:0]   prev_result_q, prev_result_d;
`else
  logic                unused_cmd_chain;
  assign unused_cmd_chain = cmd_chain;
`endif

  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    alu_op_code_d = alu_op_code_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_control_d = rsp_control_q;
    rsp_valid_d   = rsp_valid_q;
    op_count_d    = op_count_q;
`ifdef ALU_CHAIN_EN
    prev_result_d = prev_result_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          alu_op_code_d = cmd_op;
          alu_a_d       = cmd_a;
`ifdef ALU_CHAIN_EN
          if (cmd_chain) alu_a_d = prev_result_q;
`endif
          alu_b_d       = cmd_b;
          settle_cnt_d  = 4'(SETTLE_CYCLES - 1);
          state_d       = DRIVE;
        end
      end
      DRIVE: begin
        // Counter reaching zero marks the last settle cycle; capture on that edge.
        if (settle_cnt_q != 4'd0) begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end else begin
          rsp_result_d  = alu_result;
          rsp_zero_d    = alu_zero;
          rsp_control_d = alu_control;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
`ifdef ALU_CHAIN_EN
          prev_result_d = rsp_result_q[DATA_W-1:0];
`endif
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      settle_cnt_q  <= 4'd0;
      alu_op_code_q <= 3'd0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_control_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      op_count_q    <= '0;
`ifdef ALU_CHAIN_EN
      prev_result_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      alu_op_code_q <= alu_op_code_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_control_q <= rsp_control_d;
      rsp_valid_q   <= rsp_valid_d;
      op_count_q    <= op_count_d;
`ifdef ALU_CHAIN_EN
      prev_result_q <= prev_result_d;
`endif
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign alu_op_code = alu_op_code_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_control = rsp_control_q;
  assign op_count    = op_count_q;

endmodule
